uart_rx_fifo: RTL and testbench

- Synthesizable UART receiver (8N1, LSB first) with a show-ahead receive FIFO.
- Consumes a serial line such as the SoC's `ser_tx`, or an external `ser_rx` pin, and hands bytes to a downstream consumer over a valid/ready handshake.
- Used on-chip as the receive path beside the SoC UART, and in benches as a checkable byte sink that replaces ad-hoc serial monitors.
- Bit timing and error detection are decided here; the consumer sees only whole bytes plus error pulses.

---
 rtl/uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//   UART receiver (8N1, LSB first) feeding a show-ahead receive FIFO.
//   The serial input is synchronised, framed by a small FSM that samples
//   each bit at its centre, and completed bytes are pushed into the FIFO.
//   The consumer drains bytes over a valid/ready handshake and sees
//   framing errors and dropped bytes only as single-cycle pulses.
//
// Parameters
//   CLKDIV      clock cycles per serial bit (>= 4)
//   FIFO_DEPTH  receive FIFO entries (power of two, >= 2)
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   ser_rx     asynchronous serial input, idle high
//   rx_data    byte at FIFO head (0 while rx_valid=0)
//   rx_valid   FIFO not empty
//   rx_ready   consumer accepts rx_data this cycle
//   frame_err  one-cycle pulse: stop bit sampled low
//   overflow   one-cycle pulse: received byte dropped because FIFO full
//   rx_busy    receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int CLKDIV     = 104,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overflow,
    output logic       rx_busy
);

    localparam int DIV_W       = $clog2(CLKDIV) + 1;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [DIV_W-1:0] HALF_LOAD = DIV_W'(CLKDIV / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LOAD = DIV_W'(CLKDIV - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

    // -----------------------------------------------------------------------
    // Input synchroniser. Stages reset to the idle level so that a reset
    // never looks like a start bit.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rxs;

    generate
        for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= ser_rx;
                end
            end else begin : g_next
                always_ff @(posedge clk) begin
                    if (reset) sync_reg[gi] <= 1'b1;
                    else       sync_reg[gi] <= sync_reg[gi-1];
                end
            end
        end
    endgenerate

    assign rxs = sync_reg[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Receiver FSM
    // -----------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t             state_reg, state_next;
    logic [DIV_W-1:0]   divcnt_reg, divcnt_next;
    logic [2:0]         bitcnt_reg, bitcnt_next;
    logic [7:0]         sh_reg, sh_next;
    logic               push_req;
    logic               frame_err_reg, frame_err_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            divcnt_reg    <= '0;
            bitcnt_reg    <= '0;
            sh_reg        <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            divcnt_reg    <= divcnt_next;
            bitcnt_reg    <= bitcnt_next;
            sh_reg        <= sh_next;
            frame_err_reg <= frame_err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        divcnt_next    = divcnt_reg;
        bitcnt_next    = bitcnt_reg;
        sh_next        = sh_reg;
        push_req       = 1'b0;
        frame_err_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                // Half a bit to reach the middle of the start bit.
                if (!rxs) begin
                    state_next  = S_START;
                    divcnt_next = HALF_LOAD;
                end
            end

            S_START: begin
                if (divcnt_reg == '0) begin
                    if (!rxs) begin
                        state_next  = S_DATA;
                        divcnt_next = FULL_LOAD;
                        bitcnt_next = 3'd0;
                    end else begin
                        // Line went high again before mid-bit: a glitch.
                        state_next = S_IDLE;
                    end
                end else begin
                    divcnt_next = divcnt_reg - 1'b1;
                end
            end

            S_DATA: begin
                if (divcnt_reg == '0) begin
                    sh_next     = {rxs, sh_reg[7:1]};
                    divcnt_next = FULL_LOAD;
                    if (bitcnt_reg == 3'd7) begin
                        state_next = S_STOP;
                    end else begin
                        bitcnt_next = bitcnt_reg + 3'd1;
                    end
                end else begin
                    divcnt_next = divcnt_reg - 1'b1;
                end
            end

            S_STOP: begin
                if (divcnt_reg == '0) begin
                    if (rxs) begin
                        // Return to idle at mid stop bit so a start bit that
                        // immediately follows is caught.
                        push_req   = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        frame_err_next = 1'b1;
                        state_next     = S_WAIT_HIGH;
                    end
                end else begin
                    divcnt_next = divcnt_reg - 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) reports a single framing error.
                if (rxs) state_next = S_IDLE;
            end

            default: state_next = S_IDLE;
        endcase
    end

    assign rx_busy   = (state_reg != S_IDLE);
    assign frame_err = frame_err_reg;

    // -----------------------------------------------------------------------
    // Receive FIFO (show-ahead)
    // -----------------------------------------------------------------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             overflow_reg;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign full     = (count_reg == DEPTH_CNT);
    assign rx_valid = (count_reg != '0);
    assign pop      = rx_valid && rx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok  = push_req && (!full || pop);
    assign drop     = push_req && full && !pop;

    always_ff @(posedge clk) begin
        if (push_ok && !reset) begin
            mem[wr_ptr_reg] <= sh_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            overflow_reg <= drop;
            if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)     rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head entry is driven to zero while empty so the output is defined
    // after reset without clearing the storage array.
    assign rx_data  = rx_valid ? mem[rd_ptr_reg] : 8'h00;
    assign overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//   Directed bench for uart_rx_fifo (CLKDIV=104, FIFO_DEPTH=8). Frames are
//   driven bit by bit on ser_rx; a negedge monitor records every accepted
//   byte and counts frame_err / overflow pulses.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

    localparam int BIT = 104;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ser_rx = 1'b1;
    logic       rx_ready = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overflow;
    logic       rx_busy;

    uart_rx_fifo #(.CLKDIV(BIT), .FIFO_DEPTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ser_rx    (ser_rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overflow  (overflow),
        .rx_busy   (rx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int last_pop_cyc = 0;
    logic [7:0] rxq[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            rxq.push_back(rx_data);
            last_pop_cyc = cyc;
        end
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance n cycles, landing 2 time units after the rising edge.
    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // One 8N1 frame; stop_low > 0 holds the stop bit low that many cycles first.
    task automatic send_frame(input logic [7:0] b, input int stop_low);
        ser_rx = 1'b0;
        wait_cyc(BIT);
        for (int i = 0; i < 8; i++) begin
            ser_rx = b[i];
            wait_cyc(BIT);
        end
        if (stop_low > 0) begin
            ser_rx = 1'b0;
            wait_cyc(stop_low);
        end
        ser_rx = 1'b1;
        wait_cyc(BIT);
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [31:0] got;
        if (rxq.size() > 0) got = {24'h0, rxq.pop_front()};
        else                got = 32'hDEAD_BEEF;
        check(tag, got, {24'h0, exp});
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int t0;
        int fe0;
        int ov0;

        // ---------------- reset ----------------
        wait_cyc(5);
        check("rst_rx_valid",  32'(rx_valid),  32'd0);
        check("rst_rx_data",   32'(rx_data),   32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overflow",  32'(overflow),  32'd0);
        check("rst_rx_busy",   32'(rx_busy),   32'd0);
        reset = 1'b0;
        wait_cyc(5);

        // ---------------- single byte ----------------
        rx_ready = 1'b1;
        t0 = cyc;
        send_frame(8'h55, 0);
        wait_cyc(20);
        expect_byte("single_0x55", 8'h55);
        check("single_latency_ok", 32'((last_pop_cyc - t0) <= 995), 32'd1);
        check("single_extra", 32'(rxq.size()), 32'd0);
        check("single_fe", 32'(fe_cnt), 32'd0);
        check("single_ov", 32'(ov_cnt), 32'd0);

        // ---------------- glitch ----------------
        ser_rx = 1'b0;
        wait_cyc(20);
        ser_rx = 1'b1;
        wait_cyc(40);
        check("glitch_busy_clear", 32'(rx_busy), 32'd0);
        wait_cyc(200);
        check("glitch_no_byte", 32'(rxq.size()), 32'd0);

        // ---------------- back-to-back ----------------
        send_frame(8'h48, 0);
        send_frame(8'h69, 0);
        wait_cyc(60);
        expect_byte("b2b_first",  8'h48);
        expect_byte("b2b_second", 8'h69);

        // ---------------- framing error ----------------
        fe0 = fe_cnt;
        send_frame(8'hA3, 300);
        wait_cyc(200);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_no_push", 32'(rxq.size()), 32'd0);
        send_frame(8'h3C, 0);
        wait_cyc(60);
        expect_byte("ferr_next_0x3c", 8'h3C);

        // ---------------- overflow ----------------
        rx_ready = 1'b0;
        ov0 = ov_cnt;
        for (int i = 0; i < 9; i++) send_frame(8'(i), 0);
        wait_cyc(60);
        check("ovf_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("ovf_valid_held", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("ovf_drain_valid_%0d", i), 32'(rx_valid), 32'd1);
            check($sformatf("ovf_drain_data_%0d", i), 32'(rx_data), 32'(i));
        end
        @(negedge clk);
        check("ovf_drained_empty", 32'(rx_valid), 32'd0);
        wait_cyc(1);
        rxq.delete();

        // ---------------- full with simultaneous pop ----------------
        rx_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 0);
        wait_cyc(60);
        check("fullpop_valid", 32'(rx_valid), 32'd1);
        ov0 = ov_cnt;
        fork
            send_frame(8'h77, 0);
            begin
                // Frame start at P0+2: the stop sample is taken in cycle 990..991.
                wait_cyc(990);
                rx_ready = 1'b1;
                wait_cyc(1);
                rx_ready = 1'b0;
            end
        join
        wait_cyc(60);
        check("fullpop_no_ovf", 32'(ov_cnt - ov0), 32'd0);
        check("fullpop_one_popped", 32'(rxq.size()), 32'd1);
        expect_byte("fullpop_head", 8'h10);
        rx_ready = 1'b1;
        wait_cyc(12);
        for (int i = 1; i < 8; i++) expect_byte($sformatf("fullpop_drain_%0d", i), 8'h10 + 8'(i));
        expect_byte("fullpop_last_0x77", 8'h77);
        check("fullpop_empty", 32'(rx_valid), 32'd0);

        // ---------------- reset mid-frame ----------------
        rx_ready = 1'b1;
        fork
            send_frame(8'hF0, 0);
            begin
                // Cycle 600 lies in data bit 4 (a high bit), so no false start follows.
                wait_cyc(600);
                reset = 1'b1;
                wait_cyc(1);
                reset = 1'b0;
                check("midrst_busy",      32'(rx_busy),   32'd0);
                check("midrst_valid",     32'(rx_valid),  32'd0);
                check("midrst_data",      32'(rx_data),   32'd0);
                check("midrst_frame_err", 32'(frame_err), 32'd0);
                check("midrst_overflow",  32'(overflow),  32'd0);
            end
        join
        wait_cyc(200);
        check("midrst_no_push", 32'(rxq.size()), 32'd0);
        send_frame(8'h0F, 0);
        wait_cyc(60);
        expect_byte("midrst_next_0x0f", 8'h0F);
        check("end_fe_total", 32'(fe_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
